// File: rtl/mips_pkg.sv
// Shared definitions for the instruction-memory responder: FSM states,
// the NOP word returned on errors and the memory timeout limit.
package mips_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_WAIT    = 2'd2,
        ST_DISCARD = 2'd3
    } imem_state_e;

    localparam logic [31:0] NOP_WORD      = 32'h0000_0000;
    localparam logic [7:0]  TIMEOUT_LIMIT = 8'd255;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/imem_line_buf.sv
// One line-buffer entry: valid bit, 30-bit word tag and 32-bit instruction,
// with the tag compare for the current fetch address.
module imem_line_buf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_inv,
    input  logic        i_wr,
    input  logic [29:0] i_wr_tag,
    input  logic [31:0] i_wr_data,
    input  logic [29:0] i_tag,
    output logic        o_hit,
    output logic [31:0] o_data
);

    logic        r_valid;
    logic [29:0] r_tag;
    logic [31:0] r_data;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_tag   <= '0;
            r_data  <= '0;
        end else if (i_inv) begin
            r_valid <= 1'b0;
        end else if (i_wr) begin
            r_valid <= 1'b1;
            r_tag   <= i_wr_tag;
            r_data  <= i_wr_data;
        end
    end

    assign o_hit  = r_valid && (r_tag == i_tag);
    assign o_data = r_data;

endmodule

// File: rtl/imem_responder.sv
// Instruction-fetch responder with a one-entry line buffer in front of a
// req/ack backing memory. Defining IMEM_PREFETCH_EN adds a next-line prefetch entry.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | serve hits / misaligned fetches, start a request on a miss
// REQ     | first cycle of a memory request (mem_req/mem_addr launched)
// WAIT    | waiting for mem_ack, timeout counter running
// DISCARD | branch seen mid-request: wait for mem_ack and drop the data
module imem_responder
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instruction_address,
    input  logic        branch,
    output logic [31:0] instruction_bus,
    output logic        stall,
    output logic        mem_req,
    output logic [29:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        addr_err,
    output logic        bus_err
);

    imem_state_e r_state;
    imem_state_e w_state_nxt;

    logic [7:0]  r_cnt;
    logic [31:0] r_ibus;
    logic        r_mem_req;
    logic [29:0] r_mem_addr;
    logic        r_addr_err;
    logic        r_bus_err;

    logic [29:0] w_tag;
    logic        w_misal;
    logic [7:0]  w_cnt_inc;
    logic        w_hit;
    logic [31:0] w_hit_data;
    logic        w_hit0;
    logic [31:0] w_data0;
    logic        w_is_pf;
    logic        w_pf_go;
    logic [29:0] w_pf_tag;

    logic        w_stall;
    logic        w_serve;
    logic        w_nop_addr;
    logic        w_fill;
    logic        w_done;
    logic        w_tmo;
    logic        w_issue;
    logic [29:0] w_issue_tag;

    assign w_tag     = instruction_address[31:2];
    assign w_misal   = is_misaligned(instruction_address);
    assign w_cnt_inc = r_cnt + 8'd1;

    // Fill tag comes from the registered request address, not the live input.
    imem_line_buf u_buf0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_inv     (w_tmo),
        .i_wr      (w_fill && !w_is_pf),
        .i_wr_tag  (r_mem_addr),
        .i_wr_data (mem_rdata),
        .i_tag     (w_tag),
        .o_hit     (w_hit0),
        .o_data    (w_data0)
    );

`ifdef IMEM_PREFETCH_EN
    logic        w_hit1;
    logic [31:0] w_data1;
    logic [29:0] w_dlv_tag;
    logic        r_is_pf;
    logic        r_pf_want;
    logic [29:0] r_pf_tag;

    imem_line_buf u_buf1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_inv     (w_tmo),
        .i_wr      (w_fill && r_is_pf),
        .i_wr_tag  (r_mem_addr),
        .i_wr_data (mem_rdata),
        .i_tag     (w_tag),
        .o_hit     (w_hit1),
        .o_data    (w_data1)
    );

    assign w_hit      = w_hit0 | w_hit1;
    assign w_hit_data = w_hit0 ? w_data0 : w_data1;
    assign w_is_pf    = r_is_pf;
    assign w_pf_go    = r_pf_want && !branch;
    assign w_pf_tag   = r_pf_tag;
    assign w_dlv_tag  = w_serve ? w_tag : r_mem_addr;

    // A prefetch is only launched from an IDLE hit, so "issue while hitting" marks it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_is_pf   <= 1'b0;
            r_pf_want <= 1'b0;
            r_pf_tag  <= '0;
        end else begin
            if (w_issue) begin
                r_is_pf <= w_hit && !w_misal && (r_state == ST_IDLE);
            end
            if (branch || w_tmo) begin
                r_pf_want <= 1'b0;
            end else if (w_issue && w_hit) begin
                r_pf_want <= 1'b0;
            end else if (w_serve || (w_fill && !r_is_pf)) begin
                r_pf_want <= (w_dlv_tag != 30'h3FFF_FFFF);
                r_pf_tag  <= w_dlv_tag + 30'd1;
            end
        end
    end
`else
    assign w_hit      = w_hit0;
    assign w_hit_data = w_data0;
    assign w_is_pf    = 1'b0;
    assign w_pf_go    = 1'b0;
    assign w_pf_tag   = '0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_stall     = 1'b0;
        w_serve     = 1'b0;
        w_nop_addr  = 1'b0;
        w_fill      = 1'b0;
        w_done      = 1'b0;
        w_tmo       = 1'b0;
        w_issue     = 1'b0;
        w_issue_tag = w_tag;
        case (r_state)
            ST_IDLE: begin
                if (w_misal) begin
                    w_nop_addr = 1'b1;
                end else if (w_hit) begin
                    w_serve = 1'b1;
                    if (w_pf_go) begin
                        w_issue     = 1'b1;
                        w_issue_tag = w_pf_tag;
                        w_state_nxt = ST_REQ;
                    end
                end else begin
                    w_stall     = 1'b1;
                    w_issue     = 1'b1;
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ, ST_WAIT: begin
                w_stall = 1'b1;
                // Branch wins over a same-cycle ack: the data is stale either way.
                if (branch) begin
                    if (mem_ack) begin
                        w_done      = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_DISCARD;
                    end
                end else if (mem_ack) begin
                    w_fill      = 1'b1;
                    w_done      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (r_state == ST_WAIT && w_cnt_inc == TIMEOUT_LIMIT) begin
                    w_tmo       = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_DISCARD: begin
                w_stall = 1'b1;
                if (mem_ack) begin
                    w_done      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (w_cnt_inc == TIMEOUT_LIMIT) begin
                    w_tmo       = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt      <= 8'd0;
            r_ibus     <= NOP_WORD;
            r_mem_req  <= 1'b0;
            r_mem_addr <= '0;
            r_addr_err <= 1'b0;
            r_bus_err  <= 1'b0;
        end else begin
            r_addr_err <= w_nop_addr;
            r_bus_err  <= w_tmo;
            r_cnt      <= (r_state == ST_WAIT || r_state == ST_DISCARD) ? w_cnt_inc : 8'd0;
            if (w_nop_addr || w_tmo) begin
                r_ibus <= NOP_WORD;
            end else if (w_serve) begin
                r_ibus <= w_hit_data;
            end else if (w_fill && !w_is_pf) begin
                r_ibus <= mem_rdata;
            end
            if (w_issue) begin
                r_mem_req  <= 1'b1;
                r_mem_addr <= w_issue_tag;
            end else if (w_done || w_tmo) begin
                r_mem_req  <= 1'b0;
            end
        end
    end

    // Stall is masked during reset so every output reads zero while rst_n is low.
    assign stall           = w_stall & rst_n;
    assign instruction_bus = r_ibus;
    assign mem_req         = r_mem_req;
    assign mem_addr        = r_mem_addr;
    assign addr_err        = r_addr_err;
    assign bus_err         = r_bus_err;

endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder: directed fetch scenarios plus a
// randomized fetch stream scored against a transaction-level buffer model.
module tb_imem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instruction_address;
    logic        branch;
    logic [31:0] instruction_bus;
    logic        stall;
    logic        mem_req;
    logic [29:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        addr_err;
    logic        bus_err;

    int checks   = 0;
    int failures = 0;

    // Reference model: one buffered line plus the word last shown on instruction_bus.
    logic        m_valid;
    logic [29:0] m_tag;
    logic [31:0] m_data;
    logic [31:0] m_ibus;

    logic [31:0] pool [6];

    imem_responder dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .instruction_address (instruction_address),
        .branch              (branch),
        .instruction_bus     (instruction_bus),
        .stall               (stall),
        .mem_req             (mem_req),
        .mem_addr            (mem_addr),
        .mem_ack             (mem_ack),
        .mem_rdata           (mem_rdata),
        .addr_err            (addr_err),
        .bus_err             (bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] memword(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic logic model_hit(input logic [31:0] a);
        return m_valid && (m_tag == a[31:2]);
    endfunction

    // Miss: memory acks dly cycles after the request appears; data must land 2+dly cycles after the fetch.
    task automatic run_miss(input logic [31:0] a, input int dly, input logic [31:0] d);
        int n;
        instruction_address = a;
        mem_ack = 1'b0;
        #1;
        chk("miss_stall", {31'b0, stall}, 32'd1);
        chk("miss_req_idle", {31'b0, mem_req}, 32'd0);
        n = 0;
        for (int g = 0; g < 300; g++) begin
            if (n > 0 && stall == 1'b0) break;
            if (n == 1) begin
                chk("miss_req", {31'b0, mem_req}, 32'd1);
                chk("miss_addr", {2'b00, mem_addr}, a >> 2);
            end
            mem_ack   = (n == dly + 1);
            mem_rdata = (n == dly + 1) ? d : $urandom;
            step();
            mem_ack = 1'b0;
            n++;
        end
        chk("miss_latency", n, 2 + dly);
        chk("miss_data", instruction_bus, d);
        chk("miss_req_drop", {31'b0, mem_req}, 32'd0);
        m_valid = 1'b1;
        m_tag   = a[31:2];
        m_data  = d;
        m_ibus  = d;
    endtask

    // Hit or misaligned fetch; a stray mem_ack in IDLE must have no effect.
    task automatic quick(input logic [31:0] a);
        logic misal;
        misal = (a[1:0] != 2'b00);
        instruction_address = a;
        mem_ack   = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
        #1;
        chk("quick_stall", {31'b0, stall}, 32'd0);
        step();
        mem_ack = 1'b0;
        if (misal) begin
            chk("misal_err", {31'b0, addr_err}, 32'd1);
            chk("misal_nop", instruction_bus, 32'h0);
            m_ibus = 32'h0;
        end else begin
            chk("hit_err", {31'b0, addr_err}, 32'd0);
            chk("hit_data", instruction_bus, m_data);
            m_ibus = m_data;
        end
        chk("quick_no_req", {31'b0, mem_req}, 32'd0);
    endtask

    task automatic fetch_any(input logic [31:0] a);
        if (a[1:0] != 2'b00 || model_hit(a)) quick(a);
        else run_miss(a, $urandom_range(1, 6), memword(a));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ibus"}, instruction_bus, 32'h0);
        chk({tag, "_stall"}, {31'b0, stall}, 32'd0);
        chk({tag, "_req"}, {31'b0, mem_req}, 32'd0);
        chk({tag, "_addr"}, {2'b00, mem_addr}, 32'h0);
        chk({tag, "_aerr"}, {31'b0, addr_err}, 32'd0);
        chk({tag, "_berr"}, {31'b0, bus_err}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int nd;
        pool[0] = 32'h0040_0000; pool[1] = 32'h0040_0004; pool[2] = 32'h0040_0008;
        pool[3] = 32'h1356_9874; pool[4] = 32'hFFFF_FFFC; pool[5] = 32'h8000_0010;

        rst_n = 1'b0;
        instruction_address = 32'h0040_0000;
        branch    = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        repeat (3) step();
        check_all_zero("reset");
        m_valid = 1'b0; m_tag = '0; m_data = '0; m_ibus = 32'h0;
        rst_n = 1'b1;

        // Cold miss then hit.
        run_miss(32'h0040_0000, 3, 32'h27bd_ffd0);
        quick(32'h0040_0000);
        // Misaligned fetch.
        quick(32'h0040_0002);

        // Branch while waiting: fetched word must never reach the bus.
        instruction_address = 32'h0040_0004;
        #1;
        chk("br_stall", {31'b0, stall}, 32'd1);
        step();
        step();
        chk("br_wait_req", {31'b0, mem_req}, 32'd1);
        chk("br_wait_addr", {2'b00, mem_addr}, 32'h0040_0004 >> 2);
        branch = 1'b1;
        instruction_address = 32'h1356_9874;
        step();
        branch = 1'b0;
        nd = $urandom_range(1, 4);
        for (int i = 0; i < nd; i++) begin
            chk("br_discard_stall", {31'b0, stall}, 32'd1);
            chk("br_hold_req", {31'b0, mem_req}, 32'd1);
            mem_ack   = (i == nd - 1);
            mem_rdata = 32'h0062_1021;
            step();
            mem_ack = 1'b0;
            chk("br_no_stale", instruction_bus, m_ibus);
        end
        chk("br_req_done", {31'b0, mem_req}, 32'd0);
        run_miss(32'h1356_9874, 2, memword(32'h1356_9874));
        fetch_any(32'h0040_0004);

        // Branch together with ack: branch wins, data dropped.
        instruction_address = 32'h0040_0010;
        #1;
        step();
        step();
        branch    = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        instruction_address = 32'h0040_0000;
        step();
        branch  = 1'b0;
        mem_ack = 1'b0;
        chk("bra_no_data", instruction_bus, m_ibus);
        chk("bra_req_drop", {31'b0, mem_req}, 32'd0);
        chk("bra_restall", {31'b0, stall}, {31'b0, !model_hit(32'h0040_0000)});
        fetch_any(32'h0040_0000);

        // Timeout: ack withheld.
        instruction_address = 32'h0040_0020;
        #1;
        chk("tmo_stall", {31'b0, stall}, 32'd1);
        n = 0;
        for (int g = 0; g < 400; g++) begin
            step();
            n++;
            if (bus_err) break;
        end
        chk("tmo_cycles", n, 257);
        chk("tmo_nop", instruction_bus, 32'h0);
        chk("tmo_req_drop", {31'b0, mem_req}, 32'd0);
        m_valid = 1'b0;
        m_ibus  = 32'h0;

        // Reset in the middle of a wait; a late ack must be ignored.
        instruction_address = 32'h0040_0008;
        step();
        chk("tmo_pulse_end", {31'b0, bus_err}, 32'd0);
        step();
        rst_n = 1'b0;
        step();
        check_all_zero("midrst");
        rst_n = 1'b1;
        instruction_address = 32'h0040_0002;
        mem_ack   = 1'b1;
        mem_rdata = 32'h0c10_0828;
        step();
        mem_ack = 1'b0;
        chk("late_ack_ibus", instruction_bus, 32'h0);
        chk("late_ack_req", {31'b0, mem_req}, 32'd0);
        chk("late_ack_aerr", {31'b0, addr_err}, 32'd1);
        m_valid = 1'b0;
        m_ibus  = 32'h0;
        run_miss(32'h0040_0000, 4, memword(32'h0040_0000));

        // Randomized fetch stream.
        for (int i = 0; i < 150; i++) begin
            logic [31:0] a;
            a = pool[$urandom_range(0, 5)];
            if ($urandom_range(0, 9) == 0) a = a | 32'($urandom_range(1, 3));
            fetch_any(a);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
